regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of registers; SHALL be a power of two, at least 2.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 reads as 0 and ignores writes and reservations.
REQ-004 Parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to the read ports.
REQ-005 Clk  input  1  single clock, all state updates on rising edge; reset is synchronous and active-low.
REQ-006 Resetb  input  1  synchronous active-low reset, sampled on rising edge of Clk.
REQ-007 RA, RB  input  AW each  read addresses; AW = clog2(DEPTH).
REQ-008 BusA, BusB  output  WIDTH each  read data for RA/RB.
REQ-009 RW  input  AW  write address.
REQ-010 BusW  input  WIDTH  write data.
REQ-011 RegWr  input  1  write enable.
REQ-012 Resv  input  1  reserve enable; marks register ResvAddr pending (scoreboard).
REQ-013 ResvAddr  input  AW  register to reserve.
REQ-014 PendA, PendB  output  1 each  pending status of RA/RB.
REQ-015 Ready  output  1  high when the clear sequence is complete and the block accepts writes.

Function
REQ-016 Reads SHALL be combinational from RA/RB; there is no read latency.
REQ-017 A write with RegWr=1 and Ready=1 SHALL update register RW on the next rising edge.
REQ-018 BYPASS=1: if RegWr=1, Ready=1 and RW==RA, BusA SHALL equal BusW in the same cycle; RB/BusB likewise.
REQ-019 BYPASS=0: reads SHALL return the stored value; new data is visible the cycle after the write.
REQ-020 ZERO_REG=1: address 0 SHALL read 0, never store a write, and never show pending, including through bypass.
REQ-021 FSM states: CLEAR and RUN; CLEAR SHALL be entered on reset; RUN is entered after the last register is cleared.
REQ-022 In CLEAR, one register per cycle SHALL be written to 0, sequenced by a pointer running 0 to DEPTH-1; pointer DEPTH-1 moves the FSM to RUN on that edge.
REQ-023 Clear duration SHALL be DEPTH cycles after Resetb deasserts; Ready SHALL rise in the cycle after the last register is cleared.
REQ-024 In CLEAR: RegWr and Resv are ignored, BusA/BusB read 0, PendA/PendB are 0.
REQ-025 Scoreboard: one pending bit per register; Resv=1 sets bit ResvAddr; a completed write clears bit RW.
REQ-026 Simultaneous Resv and RegWr on the same address: data is written and the pending bit ends SET (new producer wins).
REQ-027 PendA = pending[RA], except BYPASS=1 with a same-cycle write to RA and no same-cycle Resv to RA gives 0; PendB likewise.
REQ-028 Resv to an already-pending register SHALL leave it pending; a write to a non-pending register SHALL be legal and leave it clear.
REQ-029 Address arithmetic SHALL be unsigned AW bits; the clear pointer SHALL not wrap back into CLEAR.

Reset
REQ-030 Resetb=0 at a rising edge: FSM to CLEAR, pointer to 0, all pending bits to 0, Ready to 0.
REQ-031 Reset during CLEAR SHALL restart the clear at pointer 0; reset during RUN SHALL discard any same-edge write or reserve.
REQ-032 Register contents are undefined only until cleared; no output SHALL be X after the first reset edge.

Structure
REQ-033 FSM state encoding and clog2 helper SHALL live in shared package regfile_pkg.
REQ-034 Scoreboard SHALL be sub-module regfile_scoreboard (pending bits, set/clear, PendA/PendB) instantiated once.
REQ-035 Storage SHALL be a plain array, DEPTH x WIDTH, one write port, two read ports.

Verification
REQ-036 Reset 1 cycle, DEPTH=32 -> Ready=0 for 32 cycles then 1; all 32 registers read 0.
REQ-037 RegWr RW=5 BusW=0xDEADBEEF, RA=5 same cycle -> BusA=0xDEADBEEF that cycle (BYPASS=1), next cycle with RegWr=0 still 0xDEADBEEF.
REQ-038 RegWr RW=0 BusW=0x1234, RA=0 -> BusA=0 that cycle and after; PendA stays 0 after Resv ResvAddr=0.
REQ-039 Resv ResvAddr=7, then RA=7 -> PendA=1; RegWr RW=7 BusW=0x55 -> PendA=0 same cycle, 0x55 read.
REQ-040 Resv and RegWr both to address 3 on one edge -> register 3 holds write data, PendA(RA=3)=1 next cycle.
REQ-041 Resetb low at clear pointer 10 -> clear restarts; Ready rises DEPTH cycles after Resetb deasserts; RegWr during CLEAR has no effect.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM encoding and address-width helper for the register file
package regfile_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and reservation bus of the register file
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = clog2(DEPTH);
    logic [AW-1:0] RA, RB, RW, ResvAddr;
    logic [WIDTH-1:0] BusA, BusB, BusW;
    logic RegWr, Resv, PendA, PendB, Ready;
    modport master (
        output RA, RB, RW, BusW, RegWr, Resv, ResvAddr,
        input BusA, BusB, PendA, PendB, Ready
    );
    modport slave (
        input RA, RB, RW, BusW, RegWr, Resv, ResvAddr,
        output BusA, BusB, PendA, PendB, Ready
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with write-clear, reserve-set and forwarded status
module regfile_scoreboard #(
    parameter int DEPTH = 32,
    parameter int AW = 5,
    parameter int BYPASS = 1
) (
    input logic Clk,
    input logic Resetb,
    input logic Ready,
    input logic [AW-1:0] RA,
    input logic [AW-1:0] RB,
    input logic [AW-1:0] RW,
    input logic [AW-1:0] ResvAddr,
    input logic wrEn,
    input logic resvEn,
    output logic PendA,
    output logic PendB
);
    logic [DEPTH-1:0] pending;
    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            pending <= '0;
        end else begin
            if (wrEn) pending[RW] <= 1'b0;
            if (resvEn) pending[ResvAddr] <= 1'b1;
        end
    end
    // A write in flight retires the producer unless a new one reserves in the same cycle
    assign PendA = Ready && pending[RA] &&
                   !(BYPASS != 0 && wrEn && RW == RA && !(resvEn && ResvAddr == RA));
    assign PendB = Ready && pending[RB] &&
                   !(BYPASS != 0 && wrEn && RW == RB && !(resvEn && ResvAddr == RB));
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 2R1W register file with clear-on-reset sequencer and pending scoreboard
module regfile_mp import regfile_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS = 1
) (
    input logic Clk,
    input logic Resetb,
    regfile_mp_if.slave bus
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    state_t state;
    logic [AW-1:0] ptr;
    logic ready;
    logic [WIDTH-1:0] mem [DEPTH];
    logic wrEn, resvEn;
    assign wrEn = bus.RegWr && ready && !(ZERO_REG != 0 && bus.RW == '0);
    assign resvEn = bus.Resv && ready && !(ZERO_REG != 0 && bus.ResvAddr == '0);
    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            state <= CLEAR;
            ptr <= '0;
            ready <= 1'b0;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end
    end
    always_ff @(posedge Clk) begin
        if (Resetb) begin
            if (state == CLEAR) mem[ptr] <= '0;
            else if (wrEn) mem[bus.RW] <= bus.BusW;
        end
    end
    assign bus.BusA = (!ready || (ZERO_REG != 0 && bus.RA == '0)) ? '0 :
                      (BYPASS != 0 && wrEn && bus.RW == bus.RA) ? bus.BusW : mem[bus.RA];
    assign bus.BusB = (!ready || (ZERO_REG != 0 && bus.RB == '0)) ? '0 :
                      (BYPASS != 0 && wrEn && bus.RW == bus.RB) ? bus.BusW : mem[bus.RB];
    assign bus.Ready = ready;
    regfile_scoreboard #(.DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS)) scoreboard (
        .Clk(Clk),
        .Resetb(Resetb),
        .Ready(ready),
        .RA(bus.RA),
        .RB(bus.RB),
        .RW(bus.RW),
        .ResvAddr(bus.ResvAddr),
        .wrEn(wrEn),
        .resvEn(resvEn),
        .PendA(bus.PendA),
        .PendB(bus.PendB)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against a behavioural model
module tb_regfile_mp;
    localparam int W = 32;
    localparam int D = 32;
    logic Clk = 1'b0;
    logic Resetb = 1'b0;
    always #5 Clk = ~Clk;
    regfile_mp_if #(.WIDTH(W), .DEPTH(D)) bus();
    regfile_mp #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(1)) dut (
        .Clk(Clk),
        .Resetb(Resetb),
        .bus(bus)
    );
    int total = 0;
    int bad = 0;
    logic [W-1:0] mMem [D];
    bit mPend [D];
    bit mReady = 1'b0;
    int clearLeft = D;

    function automatic logic [W-1:0] expBus(input logic [4:0] a);
        if (!mReady || a == 0) return '0;
        if (bus.RegWr && bus.RW == a) return bus.BusW;
        return mMem[a];
    endfunction

    function automatic logic expPend(input logic [4:0] a);
        if (!mReady || a == 0) return 1'b0;
        if (bus.RegWr && bus.RW == a && !(bus.Resv && bus.ResvAddr == a)) return 1'b0;
        return mPend[a];
    endfunction

    function automatic logic [4:0] rndAddr();
        return ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    endfunction

    task automatic tick();
        @(posedge Clk);
        if (!Resetb) begin
            mReady = 1'b0;
            clearLeft = D;
            foreach (mPend[i]) mPend[i] = 1'b0;
        end else if (!mReady) begin
            clearLeft--;
            if (clearLeft == 0) begin
                mReady = 1'b1;
                foreach (mMem[i]) mMem[i] = '0;
            end
        end else begin
            if (bus.RegWr && bus.RW != 0) begin
                mMem[bus.RW] = bus.BusW;
                mPend[bus.RW] = 1'b0;
            end
            if (bus.Resv && bus.ResvAddr != 0) mPend[bus.ResvAddr] = 1'b1;
        end
    endtask

    task automatic idle();
        bus.RegWr = 1'b0;
        bus.Resv = 1'b0;
        bus.RW = '0;
        bus.BusW = '0;
        bus.ResvAddr = '0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Resetb = 1'b0;
        idle();
        bus.RA = '0;
        bus.RB = '0;
        tick();
        @(negedge Clk);
        Resetb = 1'b1;
        for (int i = 0; i < D; i++) begin
            #1;
            total++;
            if (bus.Ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_ready_low cyc=%0d got=%b exp=0", i, bus.Ready);
            end
            tick();
            @(negedge Clk);
        end
        #1;
        total++;
        if (bus.Ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_high got=%b exp=1", bus.Ready);
        end
        for (int r = 0; r < D; r++) begin
            bus.RA = 5'(r);
            bus.RB = 5'(D - 1 - r);
            #1;
            total++;
            if (bus.BusA !== '0 || bus.BusB !== '0) begin
                bad++;
                $display("FAIL reset_cleared r=%0d got=%h/%h exp=0", r, bus.BusA, bus.BusB);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge Clk);
        bus.RegWr = 1'b1;
        bus.RW = 5'd5;
        bus.BusW = 32'hDEADBEEF;
        bus.RA = 5'd5;
        #1;
        total++;
        if (bus.BusA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL bypass_same got=%h exp=deadbeef", bus.BusA);
        end
        tick();
        @(negedge Clk);
        idle();
        #1;
        total++;
        if (bus.BusA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL bypass_stored got=%h exp=deadbeef", bus.BusA);
        end
    endtask

    task automatic test_zero();
        @(negedge Clk);
        bus.RegWr = 1'b1;
        bus.RW = 5'd0;
        bus.BusW = 32'h1234;
        bus.RA = 5'd0;
        #1;
        total++;
        if (bus.BusA !== '0) begin
            bad++;
            $display("FAIL zero_bypass got=%h exp=0", bus.BusA);
        end
        tick();
        @(negedge Clk);
        idle();
        bus.Resv = 1'b1;
        bus.ResvAddr = 5'd0;
        #1;
        total++;
        if (bus.BusA !== '0 || bus.PendA !== 1'b0) begin
            bad++;
            $display("FAIL zero_store got=%h/%b exp=0/0", bus.BusA, bus.PendA);
        end
        tick();
        @(negedge Clk);
        idle();
        #1;
        total++;
        if (bus.PendA !== 1'b0) begin
            bad++;
            $display("FAIL zero_pend got=%b exp=0", bus.PendA);
        end
    endtask

    task automatic test_pend();
        @(negedge Clk);
        idle();
        bus.Resv = 1'b1;
        bus.ResvAddr = 5'd7;
        tick();
        @(negedge Clk);
        idle();
        bus.RA = 5'd7;
        #1;
        total++;
        if (bus.PendA !== 1'b1) begin
            bad++;
            $display("FAIL pend_set got=%b exp=1", bus.PendA);
        end
        bus.RegWr = 1'b1;
        bus.RW = 5'd7;
        bus.BusW = 32'h55;
        #1;
        total++;
        if (bus.PendA !== 1'b0 || bus.BusA !== 32'h55) begin
            bad++;
            $display("FAIL pend_fwd got=%b/%h exp=0/55", bus.PendA, bus.BusA);
        end
        tick();
        @(negedge Clk);
        idle();
        #1;
        total++;
        if (bus.PendA !== 1'b0 || bus.BusA !== 32'h55) begin
            bad++;
            $display("FAIL pend_clear got=%b/%h exp=0/55", bus.PendA, bus.BusA);
        end
    endtask

    task automatic test_resv_wr();
        @(negedge Clk);
        bus.Resv = 1'b1;
        bus.ResvAddr = 5'd3;
        bus.RegWr = 1'b1;
        bus.RW = 5'd3;
        bus.BusW = 32'hA5A50003;
        bus.RA = 5'd3;
        bus.RB = 5'd3;
        tick();
        @(negedge Clk);
        idle();
        #1;
        total++;
        if (bus.BusA !== 32'hA5A50003 || bus.PendA !== 1'b1 || bus.PendB !== 1'b1) begin
            bad++;
            $display("FAIL resv_wr got=%h/%b/%b exp=a5a50003/1/1", bus.BusA, bus.PendA, bus.PendB);
        end
    endtask

    task automatic test_reset_mid_clear();
        @(negedge Clk);
        Resetb = 1'b0;
        idle();
        tick();
        @(negedge Clk);
        Resetb = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        @(negedge Clk);
        Resetb = 1'b0;
        bus.RegWr = 1'b1;
        bus.RW = 5'd9;
        bus.BusW = 32'h99;
        tick();
        @(negedge Clk);
        Resetb = 1'b1;
        bus.RW = 5'd4;
        bus.BusW = 32'hFFFF;
        bus.Resv = 1'b1;
        bus.ResvAddr = 5'd4;
        bus.RA = 5'd4;
        bus.RB = 5'd9;
        for (int i = 0; i < D; i++) begin
            #1;
            total++;
            if (bus.Ready !== 1'b0 || bus.BusA !== '0 || bus.BusB !== '0 || bus.PendA !== 1'b0) begin
                bad++;
                $display("FAIL midclear_busy cyc=%0d got=%b/%h/%h/%b exp=0/0/0/0",
                         i, bus.Ready, bus.BusA, bus.BusB, bus.PendA);
            end
            tick();
            @(negedge Clk);
        end
        idle();
        #1;
        total++;
        if (bus.Ready !== 1'b1 || bus.BusA !== '0 || bus.BusB !== '0 || bus.PendA !== 1'b0) begin
            bad++;
            $display("FAIL midclear_done got=%b/%h/%h/%b exp=1/0/0/0",
                     bus.Ready, bus.BusA, bus.BusB, bus.PendA);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            @(negedge Clk);
            Resetb = ($urandom % 200 != 0);
            bus.RA = rndAddr();
            bus.RB = rndAddr();
            bus.RW = rndAddr();
            bus.ResvAddr = rndAddr();
            bus.RegWr = $urandom % 2 == 0;
            bus.Resv = $urandom % 3 == 0;
            bus.BusW = $urandom;
            #1;
            total++;
            if (bus.BusA !== expBus(bus.RA) || bus.BusB !== expBus(bus.RB) ||
                bus.PendA !== expPend(bus.RA) || bus.PendB !== expPend(bus.RB) ||
                bus.Ready !== mReady) begin
                bad++;
                $display("FAIL random n=%0d got=%h/%h/%b/%b/%b exp=%h/%h/%b/%b/%b", n,
                         bus.BusA, bus.BusB, bus.PendA, bus.PendB, bus.Ready,
                         expBus(bus.RA), expBus(bus.RB), expPend(bus.RA), expPend(bus.RB), mReady);
            end
            tick();
        end
    endtask

    initial begin
        idle();
        bus.RA = '0;
        bus.RB = '0;
        test_reset();
        test_bypass();
        test_zero();
        test_pend();
        test_resv_wr();
        test_reset_mid_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
